// File: rtl/sram_port_arbiter.sv
// Four-port request arbiter in front of the SRAM controller's 4-to-1 mux, with an acknowledge timeout guard.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: circular priority from a pointer; otherwise fixed priority (port 0 highest).
module sram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       mem_ack_i,
  output logic [1:0] select,
  output logic       mem_req_o,
  output logic [3:0] grant_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int CW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_LAST_I);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [1:0]      select_r;
  logic            mem_req_r;
  logic [3:0]      grant_r;
  logic            busy_r;
  logic            timeout_r;
  logic [CW-1:0]   cnt_r;
  logic [1:0]      winner_s;

  // Offset of the lowest-index asserted bit; callers rotate the vector first.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] off;
    casez (v)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_r;
  logic [7:0] rot_s;

  // Rotate requests so the pointer's port sits at bit 0, then add the pointer back.
  always_comb begin
    rot_s    = {req_i, req_i} >> ptr_r;
    winner_s = ptr_r + first_set(rot_s[3:0]);
  end

  // Priority pointer advances past the port that just completed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= 2'd0;
    end else if (state_r == ST_DONE) begin
      ptr_r <= select_r + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority: port 0 highest.
  always_comb begin
    winner_s = first_set(req_i);
  end
`endif

  // Main FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      select_r  <= 2'd0;
      mem_req_r <= 1'b0;
      grant_r   <= 4'd0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_i != 4'd0) begin
            select_r  <= winner_s;
            mem_req_r <= 1'b1;
            busy_r    <= 1'b1;
            cnt_r     <= '0;
            state_r   <= ST_REQ;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // Acknowledge wins over a timeout landing in the same cycle.
          if (mem_ack_i) begin
            mem_req_r <= 1'b0;
            grant_r   <= 4'd1 << select_r;
            timeout_r <= 1'b0;
            state_r   <= ST_DONE;
          end else if (TMO_EN && (cnt_r == TMO_LAST)) begin
            mem_req_r <= 1'b0;
            grant_r   <= 4'd1 << select_r;
            timeout_r <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            cnt_r     <= TMO_EN ? cnt_r + 1'b1 : cnt_r;
          end
        end
        ST_DONE: begin
          grant_r   <= 4'd0;
          timeout_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
          grant_r   <= 4'd0;
          busy_r    <= 1'b0;
          timeout_r <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

  assign select    = select_r;
  assign mem_req_o = mem_req_r;
  assign grant_o   = grant_r;
  assign busy_o    = busy_r;
  assign timeout_o = timeout_r;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter: three instances with timeouts of 8, 4 and 0 cycles.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0] req8 = 4'd0, req4 = 4'd0, req0 = 4'd0;
  logic       ack8 = 1'b0, ack4 = 1'b0, ack0 = 1'b0;
  logic [1:0] sel8, sel4, sel0;
  logic       mreq8, mreq4, mreq0;
  logic [3:0] gnt8, gnt4, gnt0;
  logic       busy8, busy4, busy0;
  logic       tmo8, tmo4, tmo0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.TIMEOUT_CYCLES(8)) u_t8 (
    .clk(clk), .rst_n(rst_n), .req_i(req8), .mem_ack_i(ack8), .select(sel8),
    .mem_req_o(mreq8), .grant_o(gnt8), .busy_o(busy8), .timeout_o(tmo8));

  sram_port_arbiter #(.TIMEOUT_CYCLES(4)) u_t4 (
    .clk(clk), .rst_n(rst_n), .req_i(req4), .mem_ack_i(ack4), .select(sel4),
    .mem_req_o(mreq4), .grant_o(gnt4), .busy_o(busy4), .timeout_o(tmo4));

  sram_port_arbiter #(.TIMEOUT_CYCLES(0)) u_t0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .mem_ack_i(ack0), .select(sel0),
    .mem_req_o(mreq0), .grant_o(gnt0), .busy_o(busy0), .timeout_o(tmo0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req8 = 4'd0; req4 = 4'd0; req0 = 4'd0;
    ack8 = 1'b0; ack4 = 1'b0; ack0 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int exp_order[$];
    logic [3:0] pend;
    bit keep_first;
    int waited;
    int cnt;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3};
    keep_first = 1'b0;
`else
    exp_order = '{0, 0, 1, 2, 3};
    keep_first = 1'b1;
`endif

    // Reset held with all requests high.
    rst_n = 1'b0;
    req8 = 4'b1111; req4 = 4'b1111; req0 = 4'b1111;
    repeat (3) tick();
    chk("reset_t8", {22'd0, sel8, mreq8, gnt8, busy8, tmo8}, 32'd0);
    chk("reset_t4", {22'd0, sel4, mreq4, gnt4, busy4, tmo4}, 32'd0);
    chk("reset_t0", {22'd0, sel0, mreq0, gnt0, busy0, tmo0}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_sel", {30'd0, sel8}, 32'd0);
    chk("post_reset_mreq", {31'd0, mreq8}, 32'd1);
    do_reset();

    // Single access on port 2, ack on the 4th REQ cycle.
    req8 = 4'b0100;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("single_req%0d_sel", i), {30'd0, sel8}, 32'd2);
      chk($sformatf("single_req%0d_mreq", i), {31'd0, mreq8}, 32'd1);
      chk($sformatf("single_req%0d_gnt", i), {28'd0, gnt8}, 32'd0);
      if (i == 4) ack8 = 1'b1;
      else tick();
    end
    tick();
    ack8 = 1'b0;
    req8 = 4'b0000;
    chk("single_done_gnt", {28'd0, gnt8}, 32'h4);
    chk("single_done_mreq", {31'd0, mreq8}, 32'd0);
    chk("single_done_tmo", {31'd0, tmo8}, 32'd0);
    chk("single_done_sel", {30'd0, sel8}, 32'd2);
    chk("single_done_busy", {31'd0, busy8}, 32'd1);
    tick();
    chk("single_idle_gnt", {28'd0, gnt8}, 32'd0);
    chk("single_idle_busy", {31'd0, busy8}, 32'd0);
    do_reset();

    // Grant order with all four ports requesting and immediate acks.
    pend = 4'b1111;
    req8 = pend;
    ack8 = 1'b1;
    for (int i = 0; i < exp_order.size(); i++) begin
      waited = 0;
      tick();
      while (gnt8 == 4'd0 && waited < 10) begin
        tick();
        waited++;
      end
      chk($sformatf("order%0d", i), {28'd0, gnt8}, 32'd1 << exp_order[i]);
      if (!(keep_first && i == 0)) pend = pend & ~gnt8;
      req8 = pend;
    end
    ack8 = 1'b0;
    req8 = 4'd0;
    do_reset();

    // Reset in the 2nd REQ cycle after the pointer has moved off port 0.
    req8 = 4'b0001;
    ack8 = 1'b1;
    tick();
    tick();
    chk("rstmid_pre_gnt", {28'd0, gnt8}, 32'h1);
    req8 = 4'b0000;
    ack8 = 1'b0;
    tick();
    req8 = 4'b0011;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstmid_mreq", {31'd0, mreq8}, 32'd0);
    chk("rstmid_gnt", {28'd0, gnt8}, 32'd0);
    chk("rstmid_busy", {31'd0, busy8}, 32'd0);
    tick();
    chk("rstmid_gnt2", {28'd0, gnt8}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rstmid_after_sel", {30'd0, sel8}, 32'd0);
    chk("rstmid_after_mreq", {31'd0, mreq8}, 32'd1);
    do_reset();

    // Timeout of 8 cycles on port 1.
    req8 = 4'b0010;
    tick();
    cnt = 0;
    while (mreq8 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("tmo8_len", cnt, 32'd8);
    chk("tmo8_gnt", {28'd0, gnt8}, 32'h2);
    chk("tmo8_flag", {31'd0, tmo8}, 32'd1);
    req8 = 4'd0;
    tick();
    chk("tmo8_flag_clear", {31'd0, tmo8}, 32'd0);
    chk("tmo8_gnt_clear", {28'd0, gnt8}, 32'd0);

    // Ack coincides with the final timeout cycle.
    req4 = 4'b1000;
    tick();
    repeat (3) tick();
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    req4 = 4'd0;
    chk("collide_tmo", {31'd0, tmo4}, 32'd0);
    chk("collide_gnt", {28'd0, gnt4}, 32'h8);

    // Timeout disabled: request never released.
    req0 = 4'b0001;
    tick();
    cnt = 0;
    repeat (1000) begin
      if (mreq0 && gnt0 == 4'd0) cnt++;
      tick();
    end
    chk("tmo0_hold", cnt, 32'd1000);
    chk("tmo0_gnt", {28'd0, gnt0}, 32'd0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Four-port request arbiter sitting directly upstream of the SRAM controller's 4-to-1 data/address mux. It picks one of four requesters, drives the 2-bit mux `select`, presents a single request to the SRAM controller, and waits for its acknowledge. When the access ends it returns a one-cycle completion pulse to the winning port. A timeout guard releases the port if the controller never acknowledges.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles in REQ before an abort. 0 disables the timeout.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_i`  in  4  per-port request. Bit k is held high until `grant_o[k]` has pulsed.
- `mem_ack_i`  in  1  SRAM controller access-complete strobe; sampled only in REQ.
- `select`  out  2  registered mux select, wired straight to the mux `select` input.
- `mem_req_o`  out  1  registered request to the SRAM controller.
- `grant_o`  out  4  one-hot completion pulse, one cycle, to the winning port.
- `busy_o`  out  1  high in any state other than IDLE.
- `timeout_o`  out  1  one-cycle abort flag, coincident with `grant_o`.

## Operation
- **States:** IDLE, REQ, DONE. State is encoded in registers.
- **Reset values:** state=IDLE, `select`=0, `mem_req_o`=0, `grant_o`=0, `busy_o`=0, `timeout_o`=0, priority pointer=0, timeout counter=0.
- **IDLE:**
  - If `req_i`==0, stay in IDLE.
  - Otherwise choose a winner w, load `select`<=w, set `mem_req_o`<=1, clear the counter, and go to REQ.
- **REQ:**
  - `select` is held stable and `mem_req_o`=1.
  - If `mem_ack_i`=1, go to DONE with `timeout_o`<=0.
  - Else, if `TIMEOUT_CYCLES`!=0 and counter==`TIMEOUT_CYCLES`-1, go to DONE with `timeout_o`<=1.
  - Else increment the counter.
  - `mem_ack_i` takes priority over the timeout when both occur in the same cycle.
- **DONE:**
  - `mem_req_o`=0, `grant_o`=1<<`select`, `select` still held.
  - Pointer <= `select`+1 (mod 4).
  - Go to IDLE unconditionally.
- **Winner selection (`SRAM_ARB_ROUND_ROBIN_EN` defined):** the lowest-index asserted request, searching circularly from the pointer: pointer, pointer+1, … modulo 4.
- **Requester changes:** changes to `req_i` in REQ or DONE are ignored. A request dropped mid-transaction does not abort the access.
- **`mem_ack_i` outside REQ:** ignored.
- **Counter width:** $clog2(`TIMEOUT_CYCLES`+1), minimum 1 bit. The counter never wraps because the abort fires first.

## Timing
- **Request to memory:** `req_i` sampled high at edge N in IDLE gives `select` and `mem_req_o` valid after edge N, i.e. in cycle N+1.
- **Acknowledge to completion:** `mem_ack_i` high at edge M in REQ gives `grant_o` high and `mem_req_o` low in cycle M+1 (DONE); IDLE follows in M+2.
- **Minimum transaction:** 3 cycles (IDLE, REQ, DONE) when `mem_ack_i` arrives in the first REQ cycle.
- **Back-to-back:** the earliest next `mem_req_o` is 2 cycles after `grant_o`.
- **Requester rule:** deassert `req_i[k]` at the edge that ends the `grant_o[k]` cycle, so IDLE does not re-grant a stale request.
- **Select stability:** `select` never changes while `mem_req_o`=1 or `grant_o`!=0.
- **Abort timing:** the abort reaches DONE `TIMEOUT_CYCLES` cycles after entering REQ.
- **Reset mid-operation:** `rst_n`=0 at any edge forces all reset values at that edge. `mem_req_o` falls immediately and no `grant_o` is issued.

## Configuration
- **`SRAM_ARB_ROUND_ROBIN_EN` defined:** circular priority from the pointer, as described above.
- **`SRAM_ARB_ROUND_ROBIN_EN` undefined:**
  - Fixed priority: port 0 highest, port 3 lowest.
  - The pointer register is not built.
  - All other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles while `req_i`=4'b1111 -> all outputs 0. After release, `select`=0 and `mem_req_o`=1 one cycle later.
- **Single access:** `req_i`=4'b0100, `mem_ack_i` pulsed on the 4th REQ cycle -> `select`=2 throughout, `grant_o`=4'b0100 for exactly 1 cycle, `timeout_o`=0, `busy_o` low 2 cycles after the ack.
- **Round-robin (macro on):** `req_i`=4'b1111 held, each port releasing on its grant, immediate acks -> grant order 0,1,2,3. Fixed priority (macro off), same stimulus except port 0 re-requests after its grant -> port 0 granted twice before port 1.
- **Timeout:** `TIMEOUT_CYCLES`=8, `req_i`=4'b0010, no ack -> `mem_req_o` high for exactly 8 cycles, then `grant_o`=4'b0010 and `timeout_o`=1 in the same cycle. With `TIMEOUT_CYCLES`=0 and no ack, `mem_req_o` stays high for 1000 cycles.
- **Ack/timeout collision:** `TIMEOUT_CYCLES`=4, `mem_ack_i` asserted on the 4th REQ cycle -> `timeout_o`=0 and `grant_o` asserted.
- **Reset mid-operation:** assert `rst_n`=0 in the 2nd REQ cycle -> `mem_req_o`=0 after that edge, no `grant_o` pulse, pointer back to 0.
